// File: rtl/bank_req_arrays_if.sv
// Request/status bundle between the bank selector, the per-bank request arrays
// and the downstream bank arbiter.
interface bank_req_arrays_if #(
   parameter int NUM      = 7,
   parameter int REQ_BITS = 32,
   parameter int RA_BITS  = 8
);
   logic [NUM-1:0]          push;
   logic [REQ_BITS-1:0]     in_req;
   logic [NUM-1:0]          pop;
   logic [NUM-1:0]          empty;
   logic [NUM-1:0]          full;
   logic [NUM-1:0]          mid;
   logic [NUM*RA_BITS-1:0]  last_addr;
   logic [NUM*RA_BITS-1:0]  first_addr;
   logic [NUM*REQ_BITS-1:0] head_req;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output push, in_req, pop,
      input  empty, full, mid, last_addr, first_addr, head_req, overflow, underflow
   );

   modport slave (
      input  push, in_req, pop,
      output empty, full, mid, last_addr, first_addr, head_req, overflow, underflow
   );
endinterface

// File: rtl/bank_req_arrays.sv
// Per-bank request storage: NUM independent small FIFOs with registered status,
// remembered last-pushed row and combinational head outputs.
module bank_req_arrays #(
   parameter int ARR_NUM_RD = 4,
   parameter int ARR_NUM_WR = 3,
   parameter int DEPTH      = 4,
   parameter int MID_TH     = 2,
   parameter int REQ_BITS   = 32,
   parameter int RA_BITS    = 8,
   parameter int RA_POS     = 8
) (
   input logic               clk,
   input logic               rst_n,
   bank_req_arrays_if.slave  bus
);
   localparam int NUM = ARR_NUM_RD + ARR_NUM_WR;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID_TH);

   logic [REQ_BITS-1:0] mem      [NUM][DEPTH];
   logic [PW-1:0]       wr_ptr   [NUM];
   logic [PW-1:0]       rd_ptr   [NUM];
   logic [CW-1:0]       count    [NUM];
   logic [RA_BITS-1:0]  last_row [NUM];

   logic [NUM-1:0] do_push;
   logic [NUM-1:0] do_pop;
   logic [NUM-1:0] ovf_hit;
   logic [NUM-1:0] unf_hit;
   logic           ovf_flag;
   logic           unf_flag;

   // A pop on a full array frees the slot, so a simultaneous push is still accepted.
   always_comb begin
      do_push = '0;
      do_pop  = '0;
      ovf_hit = '0;
      unf_hit = '0;
      for (int i = 0; i < NUM; i++) begin
         do_pop[i]  = bus.pop[i] && (count[i] != '0);
         do_push[i] = bus.push[i] && ((count[i] != CNT_FULL) || bus.pop[i]);
         ovf_hit[i] = bus.push[i] && (count[i] == CNT_FULL) && !bus.pop[i];
         unf_hit[i] = bus.pop[i] && (count[i] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            count[i]    <= '0;
            last_row[i] <= '0;
         end
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         for (int i = 0; i < NUM; i++) begin
            if (do_push[i]) begin
               wr_ptr[i]   <= wr_ptr[i] + 1'b1;
               last_row[i] <= bus.in_req[RA_POS +: RA_BITS];
            end
            if (do_pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            if (do_push[i] && !do_pop[i]) begin
               count[i] <= count[i] + 1'b1;
            end else if (do_pop[i] && !do_push[i]) begin
               count[i] <= count[i] - 1'b1;
            end
         end
         if (|ovf_hit) ovf_flag <= 1'b1;
         if (|unf_hit) unf_flag <= 1'b1;
      end
   end

   // Payload storage carries no reset; the head is only meaningful while non-empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM; i++) begin
         if (do_push[i]) begin
            mem[i][wr_ptr[i]] <= bus.in_req;
         end
      end
   end

   logic [NUM-1:0]          empty_v;
   logic [NUM-1:0]          full_v;
   logic [NUM-1:0]          mid_v;
   logic [NUM*RA_BITS-1:0]  last_v;
   logic [NUM*RA_BITS-1:0]  first_v;
   logic [NUM*REQ_BITS-1:0] head_v;
   logic [REQ_BITS-1:0]     head_word;

   always_comb begin
      empty_v   = '0;
      full_v    = '0;
      mid_v     = '0;
      last_v    = '0;
      first_v   = '0;
      head_v    = '0;
      head_word = '0;
      for (int i = 0; i < NUM; i++) begin
         empty_v[i] = (count[i] == '0);
         full_v[i]  = (count[i] == CNT_FULL);
         mid_v[i]   = (count[i] >= CNT_MID);
         last_v[i*RA_BITS +: RA_BITS]    = last_row[i];
         head_word                        = mem[i][rd_ptr[i]];
         head_v[i*REQ_BITS +: REQ_BITS]  = head_word;
         first_v[i*RA_BITS +: RA_BITS]   = head_word[RA_POS +: RA_BITS];
      end
   end

   assign bus.empty      = empty_v;
   assign bus.full       = full_v;
   assign bus.mid        = mid_v;
   assign bus.last_addr  = last_v;
   assign bus.first_addr = first_v;
   assign bus.head_req   = head_v;
   assign bus.overflow   = ovf_flag;
   assign bus.underflow  = unf_flag;
endmodule

// File: tb/tb_bank_req_arrays.sv
// Directed bench for bank_req_arrays: one task per scenario, inline comparisons
// against hand-computed values.
module tb_bank_req_arrays;
   localparam int NUM      = 7;
   localparam int REQ_BITS = 32;
   localparam int RA_BITS  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   bank_req_arrays_if #(.NUM(NUM), .REQ_BITS(REQ_BITS), .RA_BITS(RA_BITS)) bus();

   bank_req_arrays #(
      .ARR_NUM_RD(4), .ARR_NUM_WR(3), .DEPTH(4), .MID_TH(2),
      .REQ_BITS(REQ_BITS), .RA_BITS(RA_BITS), .RA_POS(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [7:0] row, input logic [7:0] tag);
      return {tag, 8'h9E, row, tag ^ 8'hFF};
   endfunction

   function automatic logic [7:0] la(input int i);
      return bus.last_addr[i*RA_BITS +: RA_BITS];
   endfunction

   function automatic logic [7:0] fa(input int i);
      return bus.first_addr[i*RA_BITS +: RA_BITS];
   endfunction

   function automatic logic [31:0] hr(input int i);
      return bus.head_req[i*REQ_BITS +: REQ_BITS];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.push = '0;
      bus.pop  = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      bus.push   = '0;
      bus.pop    = '0;
      bus.in_req = '0;
      rst_n      = 1'b0;
      #12;
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL reset_empty: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (bus.full !== 7'h00) begin failures++; $display("[TB] FAIL reset_full: got %h expected %h", bus.full, 7'h00); end
      checks++; if (bus.mid !== 7'h00) begin failures++; $display("[TB] FAIL reset_mid: got %h expected %h", bus.mid, 7'h00); end
      checks++; if (bus.last_addr !== 56'h0) begin failures++; $display("[TB] FAIL reset_last_addr: got %h expected 0", bus.last_addr); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
      checks++; if (bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_underflow: got %b expected 0", bus.underflow); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_push();
      bus.push   = 7'h20;
      bus.in_req = mk(8'h3C, 8'h05);
      tick();
      bus.push = '0;
      checks++; if (bus.empty !== 7'h5F) begin failures++; $display("[TB] FAIL single_empty: got %h expected %h", bus.empty, 7'h5F); end
      checks++; if (la(5) !== 8'h3C) begin failures++; $display("[TB] FAIL single_last_addr: got %h expected %h", la(5), 8'h3C); end
      checks++; if (fa(5) !== 8'h3C) begin failures++; $display("[TB] FAIL single_first_addr: got %h expected %h", fa(5), 8'h3C); end
      checks++; if (hr(5) !== mk(8'h3C, 8'h05)) begin failures++; $display("[TB] FAIL single_head_req: got %h expected %h", hr(5), mk(8'h3C, 8'h05)); end
      bus.pop = 7'h20;
      tick();
      bus.pop = '0;
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL single_drain_empty: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (la(5) !== 8'h3C) begin failures++; $display("[TB] FAIL single_last_kept: got %h expected %h", la(5), 8'h3C); end
      checks++; if (bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL single_underflow: got %b expected 0", bus.underflow); end
   endtask

   task automatic test_multi_hot();
      bus.push   = 7'h52;
      bus.in_req = mk(8'h55, 8'h11);
      tick();
      checks++; if (bus.empty !== 7'h2D) begin failures++; $display("[TB] FAIL multi_empty: got %h expected %h", bus.empty, 7'h2D); end
      checks++; if (la(4) !== 8'h55) begin failures++; $display("[TB] FAIL multi_last4: got %h expected %h", la(4), 8'h55); end
      checks++; if (hr(6) !== mk(8'h55, 8'h11)) begin failures++; $display("[TB] FAIL multi_head6: got %h expected %h", hr(6), mk(8'h55, 8'h11)); end
      checks++; if (la(0) !== 8'h00) begin failures++; $display("[TB] FAIL multi_last0: got %h expected %h", la(0), 8'h00); end
      bus.push   = 7'h02;
      bus.in_req = mk(8'h66, 8'h12);
      tick();
      bus.push = '0;
      checks++; if (bus.mid !== 7'h02) begin failures++; $display("[TB] FAIL multi_mid: got %h expected %h", bus.mid, 7'h02); end
      checks++; if (la(1) !== 8'h66) begin failures++; $display("[TB] FAIL multi_last1: got %h expected %h", la(1), 8'h66); end
      checks++; if (fa(1) !== 8'h55) begin failures++; $display("[TB] FAIL multi_first1: got %h expected %h", fa(1), 8'h55); end
      bus.pop = 7'h50;
      tick();
      checks++; if (bus.empty !== 7'h7D) begin failures++; $display("[TB] FAIL multi_pop_empty: got %h expected %h", bus.empty, 7'h7D); end
      bus.pop = 7'h02;
      tick();
      checks++; if (fa(1) !== 8'h66) begin failures++; $display("[TB] FAIL multi_first1_next: got %h expected %h", fa(1), 8'h66); end
      tick();
      bus.pop = '0;
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL multi_drained: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL multi_underflow: got %b expected 0", bus.underflow); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] q[$];
      logic [7:0] row;
      for (int k = 0; k < 4; k++) begin
         row        = 8'h10 + 8'(k);
         bus.push   = 7'h04;
         bus.in_req = mk(row, 8'h02);
         q.push_back(row);
         tick();
      end
      bus.push = '0;
      checks++; if (bus.full !== 7'h04) begin failures++; $display("[TB] FAIL fpp_filled: got %h expected %h", bus.full, 7'h04); end
      for (int k = 0; k < 6; k++) begin
         row        = 8'h20 + 8'(k);
         bus.push   = 7'h04;
         bus.pop    = 7'h04;
         bus.in_req = mk(row, 8'h02);
         void'(q.pop_front());
         q.push_back(row);
         tick();
         checks++; if (bus.full[2] !== 1'b1) begin failures++; $display("[TB] FAIL fpp_full_%0d: got %b expected 1", k, bus.full[2]); end
         checks++; if (bus.overflow !== 1'b0) begin failures++; $display("[TB] FAIL fpp_overflow_%0d: got %b expected 0", k, bus.overflow); end
         checks++; if (fa(2) !== q[0]) begin failures++; $display("[TB] FAIL fpp_head_%0d: got %h expected %h", k, fa(2), q[0]); end
      end
      bus.push = '0;
      bus.pop  = '0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (hr(2) !== mk(q[0], 8'h02)) begin failures++; $display("[TB] FAIL fpp_drain_%0d: got %h expected %h", k, hr(2), mk(q[0], 8'h02)); end
         bus.pop = 7'h04;
         void'(q.pop_front());
         tick();
         bus.pop = '0;
      end
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL fpp_empty: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (la(2) !== 8'h25) begin failures++; $display("[TB] FAIL fpp_last: got %h expected %h", la(2), 8'h25); end
   endtask

   task automatic test_empty_push_pop();
      bus.push   = 7'h08;
      bus.pop    = 7'h08;
      bus.in_req = mk(8'h77, 8'h03);
      tick();
      bus.push = '0;
      bus.pop  = '0;
      checks++; if (bus.empty[3] !== 1'b0) begin failures++; $display("[TB] FAIL epp_empty: got %b expected 0", bus.empty[3]); end
      checks++; if (bus.mid[3] !== 1'b0 || bus.full[3] !== 1'b0) begin failures++; $display("[TB] FAIL epp_count1: got mid=%b full=%b expected 0 0", bus.mid[3], bus.full[3]); end
      checks++; if (bus.underflow !== 1'b1) begin failures++; $display("[TB] FAIL epp_underflow: got %b expected 1", bus.underflow); end
      checks++; if (hr(3) !== mk(8'h77, 8'h03)) begin failures++; $display("[TB] FAIL epp_head: got %h expected %h", hr(3), mk(8'h77, 8'h03)); end
      bus.pop = 7'h08;
      tick();
      bus.pop = '0;
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL epp_drained: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (la(3) !== 8'h77) begin failures++; $display("[TB] FAIL epp_last_kept: got %h expected %h", la(3), 8'h77); end
   endtask

   task automatic test_fill_overflow();
      for (int k = 1; k <= 4; k++) begin
         bus.push   = 7'h01;
         bus.in_req = mk(8'(k), 8'h00);
         tick();
         checks++; if (bus.mid[0] !== (k >= 2)) begin failures++; $display("[TB] FAIL fill_mid_%0d: got %b expected %b", k, bus.mid[0], (k >= 2)); end
         checks++; if (bus.full[0] !== (k == 4)) begin failures++; $display("[TB] FAIL fill_full_%0d: got %b expected %b", k, bus.full[0], (k == 4)); end
      end
      bus.in_req = mk(8'h09, 8'h00);
      tick();
      bus.push = '0;
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", bus.overflow); end
      checks++; if (la(0) !== 8'h04) begin failures++; $display("[TB] FAIL ovf_last: got %h expected %h", la(0), 8'h04); end
      checks++; if (fa(0) !== 8'h01) begin failures++; $display("[TB] FAIL ovf_head: got %h expected %h", fa(0), 8'h01); end
      checks++; if (bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_underflow: got %b expected 0", bus.underflow); end
      for (int k = 1; k <= 4; k++) begin
         checks++; if (hr(0) !== mk(8'(k), 8'h00)) begin failures++; $display("[TB] FAIL fill_pop_%0d: got %h expected %h", k, hr(0), mk(8'(k), 8'h00)); end
         bus.pop = 7'h01;
         tick();
         bus.pop = '0;
      end
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL fill_empty: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (la(0) !== 8'h04) begin failures++; $display("[TB] FAIL fill_last_kept: got %h expected %h", la(0), 8'h04); end
   endtask

   task automatic test_async_reset();
      bus.push   = 7'h40;
      bus.in_req = mk(8'hAB, 8'h06);
      tick();
      bus.push = 7'h40;
      tick();
      bus.push = '0;
      bus.pop  = 7'h02;
      tick();
      bus.pop = '0;
      checks++; if (bus.underflow !== 1'b1 || bus.mid[6] !== 1'b1) begin failures++; $display("[TB] FAIL ares_pre: got unf=%b mid6=%b expected 1 1", bus.underflow, bus.mid[6]); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.empty !== 7'h7F) begin failures++; $display("[TB] FAIL ares_empty: got %h expected %h", bus.empty, 7'h7F); end
      checks++; if (bus.mid !== 7'h00 || bus.full !== 7'h00) begin failures++; $display("[TB] FAIL ares_mid_full: got %h %h expected 00 00", bus.mid, bus.full); end
      checks++; if (bus.last_addr !== 56'h0) begin failures++; $display("[TB] FAIL ares_last_addr: got %h expected 0", bus.last_addr); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL ares_flags: got %b %b expected 0 0", bus.overflow, bus.underflow); end
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_multi_hot();
      test_full_push_pop();
      test_empty_push_pop();
      apply_reset();
      checks++; if (bus.underflow !== 1'b0) begin failures++; $display("[TB] FAIL rereset_underflow: got %b expected 0", bus.underflow); end
      test_fill_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bank_req_arrays.md
Name: bank_req_arrays

Overview:
Per-bank request storage stage that sits directly downstream of the bank selector. It holds ARR_NUM_RD read arrays and ARR_NUM_WR write arrays, each a small FIFO. Each array accepts the incoming request when its push bit is set. Every cycle it returns the empty/full/mid/last_addr status that the selector uses for its next decision. It also presents each array's head request, and that head's row, to the downstream bank arbiter, which drains the arrays with pop.

Parameters:
ARR_NUM_RD, 4, number of read arrays; these are indices 0..ARR_NUM_RD-1.
ARR_NUM_WR, 3, number of write arrays; these are indices ARR_NUM_RD..NUM-1.
DEPTH, 4, entries per array; must be a power of 2 and at least 2.
MID_TH, 2, occupancy at or above which mid is asserted; range 1..DEPTH-1.
REQ_BITS, 32, width of the request payload.
RA_BITS, 8, width of the row address field.
RA_POS, 8, LSB position of the row field inside the payload.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
push  in  NUM  one bit per array; each set bit writes in_req into that array.
in_req  in  REQ_BITS  request payload, shared by all arrays.
pop  in  NUM  one bit per array; each set bit removes that array's head entry.
empty  out  NUM  per array, occupancy == 0.
full  out  NUM  per array, occupancy == DEPTH.
mid  out  NUM  per array, occupancy >= MID_TH.
last_addr  out  NUM*RA_BITS  row of the entry most recently accepted by array i, in slice [i*RA_BITS +: RA_BITS].
first_addr  out  NUM*RA_BITS  row of array i's head entry, same slicing.
head_req  out  NUM*REQ_BITS  head payload of array i, in slice [i*REQ_BITS +: REQ_BITS].
overflow  out  1  sticky error flag: a push arrived while the array was full.
underflow  out  1  sticky error flag: a pop arrived while the array was empty.
(NUM = ARR_NUM_RD + ARR_NUM_WR.)

Behaviour:
- Each array has its own storage: a write pointer, a read pointer (both log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter (log2(DEPTH)+1 bits).
- empty, full and mid are decoded from the occupancy register only, so they are glitch-free registered outputs.
- Reset (rst_n low, asynchronous) takes effect immediately and aborts any operation in progress. It clears all of the following:
  - pointers and counters to 0;
  - empty to all 1s; full and mid to all 0s;
  - last_addr to all 0s;
  - overflow and underflow to 0.
  Storage contents need not be cleared. head_req and first_addr are don't-care while empty is set.
- Push latency: a push on edge N is reflected in count, empty, full, mid and last_addr after edge N. The selector sees the new status in the following cycle.
- last_addr update: last_addr[i] is loaded with in_req[RA_POS +: RA_BITS] only on an accepted push.
  - It keeps its value when the array drains to empty, so the open row is still remembered.
  - It is not changed by pops.
- Head outputs: head_req and first_addr are a combinational read of storage at the read pointer. The head is valid whenever empty[i] is 0, including in the cycle immediately after the push into an empty array.
- Push while full: the entry is dropped, no state of that array changes, and overflow is set.
- Pop while empty: the pop is ignored and underflow is set.
- Simultaneous push and pop on a non-empty array: both take effect and occupancy is unchanged. This also holds when the array is full: the pop frees a slot and the push is accepted. No overflow is flagged in that case.
- Simultaneous push and pop on an empty array: there is no bypass. The push is accepted, the pop is ignored, underflow is set, and the array ends with occupancy 1.
- Arrays are fully independent:
  - Multi-hot push writes the same payload into every selected array.
  - Multi-hot pop pops every selected array.
  - Read and write arrays behave identically; the read/write split is a numbering convention only.
- Pointer wrap: after DEPTH accepted pushes, the write pointer returns to 0. The read pointer does the same after DEPTH pops.
- overflow and underflow are cleared only by reset.

Test Plan:
- Reset, then idle: empty=7'h7F, full=0, mid=0, last_addr=0, both error flags 0.
- Push array 5 with in_req row=0x3C: after one edge, empty[5]=0, last_addr[5]=0x3C, first_addr[5]=0x3C, and head_req[5] equals the pushed payload.
- Push array 0 four times with rows 1,2,3,4 (DEPTH=4, MID_TH=2):
  - mid[0] rises after the 2nd push; full[0] rises after the 4th;
  - a 5th push (row 9) is dropped, overflow=1, last_addr[0] stays 4;
  - pops then return rows 1,2,3,4 in order.
- With array 2 full, push and pop it in the same cycle: count stays 4, full stays 1, overflow stays 0, and the head advances. Repeat to cover pointer wrap.
- Push and pop array 3 in the same cycle while it is empty: empty[3]=0 afterwards, count=1, underflow=1. After popping it back to empty, last_addr[3] still holds the pushed row.
- Pulse rst_n low asynchronously, mid-cycle, while arrays hold data: all outputs return to their reset values before the next clock edge.
